// File: rtl/mult_lane_accumulator.sv
// Accumulates packed 16-bit multiplier products into wide per-lane sums over a
// fixed-length job, in one 16-bit lane or two 8-bit lanes, then presents the result.
module mult_lane_accumulator #(
    parameter int ACC_WIDTH = 24,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] len,
    input  logic                 HALF_1,
    input  logic                 C_sign,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [15:0]          C,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] acc_hi,
    output logic [ACC_WIDTH-1:0] acc_lo,
    output logic                 out_half,
    output logic                 busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ACC_WIDTH-1:0] ACC_ZERO = {ACC_WIDTH{1'b0}};

    logic [1:0]           state_r;
    logic [CNT_WIDTH-1:0] cnt_r;
    logic                 sign_r;
    logic                 half_r;
    logic                 out_valid_r;
    logic [ACC_WIDTH-1:0] acc_hi_r;
    logic [ACC_WIDTH-1:0] acc_lo_r;
    logic [ACC_WIDTH-1:0] add_hi_s;
    logic [ACC_WIDTH-1:0] add_lo_s;

    function automatic logic [ACC_WIDTH-1:0] ext16(input logic [15:0] v, input logic sgn);
        ext16 = {{(ACC_WIDTH-16){sgn & v[15]}}, v};
    endfunction

    function automatic logic [ACC_WIDTH-1:0] ext8(input logic [7:0] v, input logic sgn);
        ext8 = {{(ACC_WIDTH-8){sgn & v[7]}}, v};
    endfunction

    // Lane addends for the current beat, shaped by the mode latched at start
    always_comb begin
        add_hi_s = ACC_ZERO;
        add_lo_s = ACC_ZERO;
        if (half_r) begin
            add_hi_s = ext8(C[15:8], sign_r);
            add_lo_s = ext8(C[7:0], sign_r);
        end else begin
            add_hi_s = ext16(C, sign_r);
            add_lo_s = ACC_ZERO;
        end
    end

    // Job control and accumulation; out_valid is registered alongside the DONE transition
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= S_IDLE;
            cnt_r       <= CNT_ZERO;
            sign_r      <= 1'b0;
            half_r      <= 1'b0;
            out_valid_r <= 1'b0;
            acc_hi_r    <= ACC_ZERO;
            acc_lo_r    <= ACC_ZERO;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        cnt_r    <= len;
                        half_r   <= HALF_1;
                        sign_r   <= C_sign;
                        acc_hi_r <= ACC_ZERO;
                        acc_lo_r <= ACC_ZERO;
                        if (len == CNT_ZERO) begin
                            state_r     <= S_DONE;
                            out_valid_r <= 1'b1;
                        end else begin
                            state_r <= S_ACCUM;
                        end
                    end
                end
                S_ACCUM: begin
                    if (in_valid) begin
                        acc_hi_r <= acc_hi_r + add_hi_s;
                        acc_lo_r <= acc_lo_r + add_lo_s;
                        cnt_r    <= cnt_r - CNT_ONE;
                        if (cnt_r == CNT_ONE) begin
                            state_r     <= S_DONE;
                            out_valid_r <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    // Result stays frozen until the consumer takes it
                    if (out_ready) begin
                        state_r     <= S_IDLE;
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= S_IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (state_r == S_ACCUM);
    assign busy      = (state_r != S_IDLE);
    assign out_valid = out_valid_r;
    assign acc_hi    = acc_hi_r;
    assign acc_lo    = acc_lo_r;
    assign out_half  = half_r;

endmodule

// File: tb/tb_mult_lane_accumulator.sv
// Self-checking bench for mult_lane_accumulator: directed cases from the job rules plus
// randomized jobs compared against an arithmetic reference model.
module tb_mult_lane_accumulator;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  len;
    logic        HALF_1;
    logic        C_sign;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] C;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] acc_hi;
    logic [23:0] acc_lo;
    logic        out_half;
    logic        busy;

    logic        in_ready17;
    logic        out_valid17;
    logic [16:0] acc_hi17;
    logic [16:0] acc_lo17;
    logic        out_half17;
    logic        busy17;

    int compared   = 0;
    int mismatched = 0;

    logic [15:0] beats [256];

    mult_lane_accumulator #(.ACC_WIDTH(24), .CNT_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len), .HALF_1(HALF_1),
        .C_sign(C_sign), .in_valid(in_valid), .in_ready(in_ready), .C(C),
        .out_valid(out_valid), .out_ready(out_ready), .acc_hi(acc_hi),
        .acc_lo(acc_lo), .out_half(out_half), .busy(busy)
    );

    // Narrow instance on the same stimulus, used to observe 17-bit wrap-around
    mult_lane_accumulator #(.ACC_WIDTH(17), .CNT_WIDTH(8)) dut17 (
        .clk(clk), .reset(reset), .start(start), .len(len), .HALF_1(HALF_1),
        .C_sign(C_sign), .in_valid(in_valid), .in_ready(in_ready17), .C(C),
        .out_valid(out_valid17), .out_ready(out_ready), .acc_hi(acc_hi17),
        .acc_lo(acc_lo17), .out_half(out_half17), .busy(busy17)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sum of a lane over the job, reduced modulo 2^w
    function automatic longint model_sum(input int n, input bit half, input bit sgn,
                                         input bit hi, input int w);
        longint s;
        logic [15:0] b;
        logic [7:0]  l;
        s = 0;
        for (int i = 0; i < n; i++) begin
            b = beats[i];
            if (!half) begin
                if (hi) s += sgn ? longint'($signed(b)) : longint'(b);
            end else begin
                l = hi ? b[15:8] : b[7:0];
                s += sgn ? longint'($signed(l)) : longint'(l);
            end
        end
        return s & ((64'sd1 <<< w) - 64'sd1);
    endfunction

    // Starts a job and feeds its beats with stall_min..stall_max idle cycles before each
    task automatic drive_job(input int n, input bit half, input bit sgn,
                             input int stall_min, input int stall_max);
        start = 1'b1; len = 8'(n); HALF_1 = half; C_sign = sgn;
        tick();
        start = 1'b0; len = 8'($urandom); HALF_1 = 1'($urandom); C_sign = 1'($urandom);
        for (int i = 0; i < n; i++) begin
            for (int s = $urandom_range(stall_max, stall_min); s > 0; s--) begin
                in_valid = 1'b0; C = 16'($urandom);
                tick();
            end
            in_valid = 1'b1; C = beats[i];
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        compared++;
        if ({out_valid, in_ready, busy, out_half, acc_hi, acc_lo} !== 52'd0) begin
            mismatched++;
            $display("FAIL reset_state: got ov=%b ir=%b busy=%b half=%b hi=%h lo=%h expected all 0",
                     out_valid, in_ready, busy, out_half, acc_hi, acc_lo);
        end
    endtask

    task automatic test_full_signed();
        beats[0] = 16'h0100; beats[1] = 16'hFF00; beats[2] = 16'h0010;
        drive_job(3, 1'b0, 1'b1, 0, 0);
        compared++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL full_signed_latency: got ov=%b ir=%b busy=%b expected 1 0 1", out_valid, in_ready, busy);
        end
        compared++;
        if (acc_hi !== 24'h000010 || acc_lo !== 24'h0 || out_half !== 1'b0) begin
            mismatched++;
            $display("FAIL full_signed_sum: got hi=%h lo=%h half=%b expected 000010 000000 0", acc_hi, acc_lo, out_half);
        end
        take_result();
        compared++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL full_signed_handshake: got ov=%b busy=%b expected 0 0", out_valid, busy);
        end
    endtask

    task automatic test_full_unsigned();
        beats[0] = 16'h0100; beats[1] = 16'hFF00; beats[2] = 16'h0010;
        drive_job(3, 1'b0, 1'b0, 0, 1);
        compared++;
        if (out_valid !== 1'b1 || acc_hi !== 24'h010010 || acc_lo !== 24'h0) begin
            mismatched++;
            $display("FAIL full_unsigned: got ov=%b hi=%h lo=%h expected 1 010010 000000", out_valid, acc_hi, acc_lo);
        end
        take_result();
    endtask

    task automatic test_half_signed();
        beats[0] = 16'h7F80; beats[1] = 16'h7F80;
        drive_job(2, 1'b1, 1'b1, 0, 0);
        compared++;
        if (out_valid !== 1'b1 || acc_hi !== 24'h0000FE || acc_lo !== 24'hFFFF00 || out_half !== 1'b1) begin
            mismatched++;
            $display("FAIL half_signed: got ov=%b hi=%h lo=%h half=%b expected 1 0000fe ffff00 1",
                     out_valid, acc_hi, acc_lo, out_half);
        end
        take_result();
    endtask

    task automatic test_back_to_back_stalls();
        logic [23:0] held_hi;
        int bad;
        beats[0] = 16'h1234; beats[1] = 16'h0101;
        drive_job(2, 1'b0, 1'b0, 4, 4);
        held_hi = 24'h001335;
        compared++;
        if (out_valid !== 1'b1 || acc_hi !== held_hi) begin
            mismatched++;
            $display("FAIL stall_sum: got ov=%b hi=%h expected 1 %h", out_valid, acc_hi, held_hi);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; C = 16'($urandom); start = (i == 2); len = 8'd3;
            tick();
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || acc_hi !== held_hi || acc_lo !== 24'h0 || out_half !== 1'b0)
                bad++;
        end
        in_valid = 1'b0;
        compared++;
        if (bad != 0) begin
            mismatched++;
            $display("FAIL backpressure_hold: got %0d unstable cycles expected 0", bad);
        end
        start = 1'b1;
        take_result();
        start = 1'b0;
        compared++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL start_in_done_handshake: got ov=%b busy=%b expected 0 0", out_valid, busy);
        end
        tick();
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("FAIL start_in_done_ignored: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_wrap();
        beats[0] = 16'hFFFF; beats[1] = 16'hFFFF; beats[2] = 16'hFFFF;
        drive_job(3, 1'b0, 1'b0, 0, 0);
        compared++;
        if (out_valid17 !== 1'b1 || acc_hi17 !== 17'h0FFFD || acc_lo17 !== 17'h0) begin
            mismatched++;
            $display("FAIL wrap17: got ov=%b hi=%h lo=%h expected 1 0fffd 00000", out_valid17, acc_hi17, acc_lo17);
        end
        compared++;
        if (acc_hi !== 24'h02FFFD) begin
            mismatched++;
            $display("FAIL wrap24: got hi=%h expected 02fffd", acc_hi);
        end
        take_result();
    endtask

    task automatic test_zero_len();
        drive_job(0, 1'b1, 1'b1, 0, 0);
        compared++;
        if (out_valid !== 1'b1 || acc_hi !== 24'h0 || acc_lo !== 24'h0 || out_half !== 1'b1 || in_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL zero_len: got ov=%b hi=%h lo=%h half=%b ir=%b expected 1 0 0 1 0",
                     out_valid, acc_hi, acc_lo, out_half, in_ready);
        end
        take_result();
    endtask

    task automatic test_reset_midjob();
        int seen;
        start = 1'b1; len = 8'd4; HALF_1 = 1'b1; C_sign = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; C = 16'h1111;
            tick();
        end
        in_valid = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0;
        compared++;
        if ({out_valid, in_ready, busy, out_half, acc_hi, acc_lo} !== 52'd0) begin
            mismatched++;
            $display("FAIL reset_midjob: got ov=%b ir=%b busy=%b half=%b hi=%h lo=%h expected all 0",
                     out_valid, in_ready, busy, out_half, acc_hi, acc_lo);
        end
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (out_valid !== 1'b0 || busy !== 1'b0) seen++;
        end
        in_valid = 1'b0;
        compared++;
        if (seen != 0) begin
            mismatched++;
            $display("FAIL reset_midjob_no_result: got %0d active cycles expected 0", seen);
        end
        beats[0] = 16'h0005;
        drive_job(1, 1'b0, 1'b0, 0, 0);
        compared++;
        if (out_valid !== 1'b1 || acc_hi !== 24'h000005 || acc_lo !== 24'h0 || out_half !== 1'b0) begin
            mismatched++;
            $display("FAIL after_reset_job: got ov=%b hi=%h lo=%h half=%b expected 1 000005 0 0",
                     out_valid, acc_hi, acc_lo, out_half);
        end
        take_result();
    endtask

    task automatic test_random();
        int n;
        bit half, sgn;
        logic [23:0] exp_hi, exp_lo;
        int bad;
        for (int j = 0; j < 24; j++) begin
            n    = ($urandom_range(7, 0) == 0) ? 0 : $urandom_range(20, 1);
            half = 1'($urandom);
            sgn  = 1'($urandom);
            for (int i = 0; i < n; i++) beats[i] = 16'($urandom);
            exp_hi = 24'(model_sum(n, half, sgn, 1'b1, 24));
            exp_lo = 24'(model_sum(n, half, sgn, 1'b0, 24));
            drive_job(n, half, sgn, 0, 2);
            bad = 0;
            for (int d = $urandom_range(3, 0); d > 0; d--) begin
                tick();
                if (out_valid !== 1'b1 || acc_hi !== exp_hi) bad++;
            end
            compared++;
            if (out_valid !== 1'b1 || acc_hi !== exp_hi || acc_lo !== exp_lo || out_half !== half || bad != 0) begin
                mismatched++;
                $display("FAIL random_job%0d: got ov=%b hi=%h lo=%h half=%b unstable=%0d expected 1 %h %h %b 0",
                         j, out_valid, acc_hi, acc_lo, out_half, bad, exp_hi, exp_lo, half);
            end
            take_result();
            compared++;
            if (out_valid !== 1'b0) begin
                mismatched++;
                $display("FAIL random_release%0d: got ov=%b expected 0", j, out_valid);
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; len = 8'd0; HALF_1 = 1'b0; C_sign = 1'b0;
        in_valid = 1'b0; C = 16'h0; out_ready = 1'b0;
        test_reset();
        test_full_signed();
        test_full_unsigned();
        test_half_signed();
        test_back_to_back_stalls();
        test_wrap();
        test_zero_len();
        test_reset_midjob();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
